// File: rtl/binary_to_gray.sv
`default_nettype none
// ============================================================================
//  Module      : binary_to_gray
//  Description : Combinational binary-to-reflected-Gray converter for a
//                PTR+1 bit pointer (PTR address bits plus one wrap bit).
//  Revision    : 1.0 - initial release
// ============================================================================
module binary_to_gray #(
    parameter int PTR = 3
) (
    input  logic [PTR:0] i_bin,
    output logic [PTR:0] o_gray
);

    // Each Gray bit is the XOR of the binary bit and its more-significant
    // neighbour; the MSB passes straight through.
    always_comb begin
        o_gray = i_bin ^ (i_bin >> 1);
    end

endmodule
`default_nettype wire

// File: rtl/fifo_ptr_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_ptr_ctrl
//  Description : Single-clock FIFO pointer controller. Grants write/read
//                requests against the registered full/empty flags, advances
//                binary read/write pointers (one extra wrap bit), and
//                publishes registered Gray copies of both pointers together
//                with occupancy, flags and one-cycle error pulses.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_ptr_ctrl #(
    parameter int PTR = 3
) (
    input  logic           CLK_50M,
    input  logic           RST_N,
    input  logic           wr_req,
    input  logic           rd_req,
    output logic           wr_en,
    output logic           rd_en,
    output logic [PTR-1:0] wr_addr,
    output logic [PTR-1:0] rd_addr,
    output logic [PTR:0]   wr_ptr_gray,
    output logic [PTR:0]   rd_ptr_gray,
    output logic           full,
    output logic           empty,
    output logic [PTR:0]   count,
    output logic           wr_err,
    output logic           rd_err
);

    // FIFO depth expressed at pointer width; numerically it is also the
    // pattern with only the wrap bit set.
    localparam logic [PTR:0] DEPTH = (PTR+1)'(2**PTR);

    // Registered state
    logic [PTR:0] wr_bin_q,  wr_bin_d;
    logic [PTR:0] rd_bin_q,  rd_bin_d;
    logic [PTR:0] wr_gray_q, wr_gray_d;
    logic [PTR:0] rd_gray_q, rd_gray_d;
    logic [PTR:0] count_q,   count_d;
    logic         full_q,    full_d;
    logic         empty_q,   empty_d;
    logic         wr_err_q,  wr_err_d;
    logic         rd_err_q,  rd_err_d;

    logic [PTR:0] w_ptr_xor;

    // Grants look only at this cycle's registered flags; a request that
    // would be satisfied by a same-cycle opposite operation is not bypassed.
    always_comb begin
        wr_en = wr_req & ~full_q;
        rd_en = rd_req & ~empty_q;
    end

    // Next pointers, flags, occupancy and error pulses, all derived from the
    // next-state pointers so every output moves on the same edge.
    always_comb begin
        wr_bin_d  = wr_bin_q + (PTR+1)'(wr_en);
        rd_bin_d  = rd_bin_q + (PTR+1)'(rd_en);
        w_ptr_xor = wr_bin_d ^ rd_bin_d;
        empty_d   = (w_ptr_xor == '0);
        // Full: wrap bits differ while all address bits match.
        full_d    = (w_ptr_xor == DEPTH);
        count_d   = wr_bin_d - rd_bin_d;
        wr_err_d  = wr_req & full_q;
        rd_err_d  = rd_req & empty_q;
    end

    // Gray encoders operate on the next pointers so the Gray registers load
    // in lock-step with the binary registers.
    binary_to_gray #(
        .PTR (PTR)
    ) u_wr_b2g (
        .i_bin  (wr_bin_d),
        .o_gray (wr_gray_d)
    );

    binary_to_gray #(
        .PTR (PTR)
    ) u_rd_b2g (
        .i_bin  (rd_bin_d),
        .o_gray (rd_gray_d)
    );

    // State register with asynchronous clear to the empty condition.
    always_ff @(posedge CLK_50M or negedge RST_N) begin
        if (!RST_N) begin
            wr_bin_q  <= '0;
            rd_bin_q  <= '0;
            wr_gray_q <= '0;
            rd_gray_q <= '0;
            count_q   <= '0;
            full_q    <= 1'b0;
            empty_q   <= 1'b1;
            wr_err_q  <= 1'b0;
            rd_err_q  <= 1'b0;
        end else begin
            wr_bin_q  <= wr_bin_d;
            rd_bin_q  <= rd_bin_d;
            wr_gray_q <= wr_gray_d;
            rd_gray_q <= rd_gray_d;
            count_q   <= count_d;
            full_q    <= full_d;
            empty_q   <= empty_d;
            wr_err_q  <= wr_err_d;
            rd_err_q  <= rd_err_d;
        end
    end

    // Output mapping: RAM addresses drop the wrap bit.
    always_comb begin
        wr_addr     = wr_bin_q[PTR-1:0];
        rd_addr     = rd_bin_q[PTR-1:0];
        wr_ptr_gray = wr_gray_q;
        rd_ptr_gray = rd_gray_q;
        full        = full_q;
        empty       = empty_q;
        count       = count_q;
        wr_err      = wr_err_q;
        rd_err      = rd_err_q;
    end

endmodule
`default_nettype wire
